// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings plus
// the shift-amount width helper used by the datapath and the iterative engine.
package alu_pkg;

  typedef enum logic [3:0] {
    MODE_ADD   = 4'd0,
    MODE_SUB   = 4'd1,
    MODE_AND   = 4'd2,
    MODE_OR    = 4'd3,
    MODE_XOR   = 4'd4,
    MODE_SLL   = 4'd5,
    MODE_SRL   = 4'd6,
    MODE_PASS  = 4'd7,
    MODE_SRA   = 4'd8,
    MODE_SLT   = 4'd9,
    MODE_SLTU  = 4'd10,
    MODE_MUL   = 4'd11,
    MODE_DIVU  = 4'd12,
    MODE_REMU  = 4'd13,
    MODE_RSV14 = 4'd14,
    MODE_RSV15 = 4'd15
  } alu_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int shamt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: one shift-add multiply step or one restoring-divide step
// per cycle, DATA_WIDTH steps per operation.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = shamt_w(DATA_WIDTH);

  logic [W-1:0]  acc, mcand, mplier;
  logic [W-1:0]  rem, quo, dvsr;
  logic [CW-1:0] cnt;
  logic          div_q;

  logic [W-1:0]  acc_nxt, rem_nxt, quo_nxt;
  logic [W:0]    shifted, diff;

  // Outputs carry the post-step values so the parent can register the final
  // answer on the same edge that performs the last step.
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dvsr};
    rem_nxt = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    quo_nxt = {quo[W-2:0], ~diff[W]};
  end

  assign done      = busy && (cnt == '0);
  assign product   = acc_nxt;
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      div_q  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(W - 1);
      div_q  <= is_div;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      rem    <= '0;
      quo    <= a;
      dvsr   <= b;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
      if (div_q) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
      end else begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked registered ALU: single-cycle ops complete in one cycle, MUL/DIVU/REMU
// run on the iterative engine while the issuing stage is stalled.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit MUL_EN     = 1'b1,
  parameter bit DIV_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            mode,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag_zero,
  output logic                  flag_neg,
  output logic                  flag_carry,
  output logic                  err
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = shamt_w(DATA_WIDTH);

  alu_mode_t m, mode_q;
  state_t    state, state_nxt;
  logic      accept, is_mul, is_div, is_multi, is_rsv;

  assign m = alu_mode_t'(mode);

  always_comb begin
    is_mul   = (m == MODE_MUL) && MUL_EN;
    is_div   = ((m == MODE_DIVU) || (m == MODE_REMU)) && DIV_EN;
    is_multi = is_mul || is_div;
    is_rsv   = (m == MODE_RSV14) || (m == MODE_RSV15) ||
               ((m == MODE_MUL) && !MUL_EN) ||
               (((m == MODE_DIVU) || (m == MODE_REMU)) && !DIV_EN);
  end

  // Single-cycle datapath; disabled or reserved modes fall to the zero default.
  logic [SHW-1:0]      shamt;
  logic [W:0]          sum, dif;
  logic signed [W-1:0] op1_s, op2_s;
  logic [W-1:0]        sc_res;
  logic                sc_carry;

  assign shamt = op2[SHW-1:0];
  assign sum   = {1'b0, op1} + {1'b0, op2};
  assign dif   = {1'b0, op1} - {1'b0, op2};
  assign op1_s = op1;
  assign op2_s = op2;

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    case (m)
      MODE_ADD:  begin sc_res = sum[W-1:0]; sc_carry = sum[W]; end
      MODE_SUB:  begin sc_res = dif[W-1:0]; sc_carry = dif[W]; end
      MODE_AND:  sc_res = op1 & op2;
      MODE_OR:   sc_res = op1 | op2;
      MODE_XOR:  sc_res = op1 ^ op2;
      MODE_SLL:  sc_res = op1 << shamt;
      MODE_SRL:  sc_res = op1 >> shamt;
      MODE_PASS: sc_res = op1;
      MODE_SRA:  sc_res = op1_s >>> shamt;
      MODE_SLT:  sc_res = {{(W-1){1'b0}}, (op1_s < op2_s)};
      MODE_SLTU: sc_res = {{(W-1){1'b0}}, (op1 < op2)};
      default:   sc_res = '0;
    endcase
  end

  logic         eng_start, eng_busy, eng_done, eng_fin;
  logic [W-1:0] eng_prod, eng_quo, eng_rem, eng_res;

  assign eng_start = accept && is_multi;
  assign eng_fin   = eng_busy && eng_done;

  generate
    if (MUL_EN || DIV_EN) begin : g_eng
      alu_iter_muldiv #(.DATA_WIDTH(W)) u_eng (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (eng_start),
        .is_div    (is_div),
        .a         (op1),
        .b         (op2),
        .busy      (eng_busy),
        .done      (eng_done),
        .product   (eng_prod),
        .quotient  (eng_quo),
        .remainder (eng_rem)
      );
    end else begin : g_no_eng
      assign eng_busy = 1'b0;
      assign eng_done = 1'b0;
      assign eng_prod = '0;
      assign eng_quo  = '0;
      assign eng_rem  = '0;
    end
  endgenerate

  always_comb begin
    case (mode_q)
      MODE_MUL:  eng_res = eng_prod;
      MODE_DIVU: eng_res = eng_quo;
      default:   eng_res = eng_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_multi ? BUSY : DONE;
      BUSY: if (eng_fin) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = is_multi ? BUSY : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Result/flag register: loaded on single-cycle accept or on the engine's last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_ADD;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
      flag_carry <= 1'b0;
      err        <= 1'b0;
    end else if (accept) begin
      mode_q <= m;
      if (!is_multi) begin
        result     <= sc_res;
        flag_zero  <= (sc_res == '0);
        flag_neg   <= sc_res[W-1];
        flag_carry <= sc_carry;
        err        <= is_rsv;
      end
    end else if (state == BUSY && eng_fin) begin
      result     <= eng_res;
      flag_zero  <= (eng_res == '0);
      flag_neg   <= eng_res[W-1];
      flag_carry <= 1'b0;
      err        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against a plain-arithmetic reference.
module tb_alu_seq;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    mode;
  logic [DW-1:0] op1, op2, result;
  logic          flag_zero, flag_neg, flag_carry, err;

  logic          in_valid2, in_ready2, out_valid2, out_ready2;
  logic [3:0]    mode2;
  logic [DW-1:0] op1_2, op2_2, result2;
  logic          fz2, fn2, fc2, err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .op1(op1), .op2(op2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_zero(flag_zero),
    .flag_neg(flag_neg), .flag_carry(flag_carry), .err(err)
  );

  alu_seq #(.DATA_WIDTH(DW), .MUL_EN(1'b0), .DIV_EN(1'b1)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .mode(mode2), .op1(op1_2), .op2(op2_2), .out_valid(out_valid2),
    .out_ready(out_ready2), .result(result2), .flag_zero(fz2),
    .flag_neg(fn2), .flag_carry(fc2), .err(err2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] m, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input bit mul_en,
                                output logic [DW-1:0] r, output logic c,
                                output logic e);
    logic [DW:0] t;
    r = '0; c = 1'b0; e = 1'b0;
    case (m)
      4'd0:  begin t = {1'b0, a} + {1'b0, b}; r = t[DW-1:0]; c = t[DW]; end
      4'd1:  begin r = a - b; c = (a < b); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = a;
      4'd8:  r = $signed(a) >>> b[4:0];
      4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: if (mul_en) r = a * b; else e = 1'b1;
      4'd12: if (b == 0) r = '1; else r = a / b;
      4'd13: if (b == 0) r = a; else r = a % b;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] er;
    logic          ec, ee;
    int            n, lat, explat;
    bit            rdy_leak;
    model(m, a, b, 1'b1, er, ec, ee);
    explat = (m >= 4'd11 && m <= 4'd13) ? DW + 1 : 1;
    @(negedge clk);
    in_valid = 1'b1; mode = m; op1 = a; op2 = b; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept_timeout", n >= 200, 0);
    if (n >= 200) return;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op1 = $urandom; op2 = $urandom;
    lat = 0; rdy_leak = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) rdy_leak = 1;
    end while (!out_valid && lat < 200);
    chk($sformatf("lat m%0d", m), lat, explat);
    chk($sformatf("res m%0d a=%h b=%h", m, a, b), result, er);
    chk($sformatf("zero m%0d", m), flag_zero, (er == 0));
    chk($sformatf("neg m%0d", m), flag_neg, er[DW-1]);
    chk($sformatf("carry m%0d", m), flag_carry, ec);
    chk($sformatf("err m%0d", m), err, ee);
    chk($sformatf("busy_rdy m%0d", m), rdy_leak, 0);
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return DW'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] xq[$];
    logic [DW-1:0] xa, xb;
    bit            seen;
    rst_n = 1'b0; in_valid = 1'b0; mode = '0; op1 = '0; op2 = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; mode2 = '0; op1_2 = '0; op2_2 = '0; out_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst flags", {flag_zero, flag_neg, flag_carry}, 0);
    chk("rst err", err, 0);
    chk("rst in_ready", in_ready, 1);
    rst_n = 1'b1;

    run_op(4'd0, 32'hFFFF_FFFF, 32'h1);
    run_op(4'd1, 32'd3, 32'd5);
    run_op(4'd8, 32'h8000_0000, 32'h24);
    run_op(4'd9, 32'hFFFF_FFFF, 32'd1);
    run_op(4'd10, 32'hFFFF_FFFF, 32'd1);
    run_op(4'd11, 32'd7, 32'd6);
    run_op(4'd12, 32'd100, 32'd7);
    run_op(4'd13, 32'd100, 32'd7);
    run_op(4'd12, 32'd5, 32'd0);
    run_op(4'd13, 32'd5, 32'd0);
    run_op(4'd15, 32'h1234, 32'd5);
    run_op(4'd14, 32'hFFFF, 32'hFFFF);

    // Backpressure: result must stay put while the consumer stalls.
    @(negedge clk);
    in_valid = 1'b1; mode = 4'd0; op1 = 32'd1; op2 = 32'd2; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid", out_valid, 1);
      chk("bp result", result, 3);
      chk("bp in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp retired", out_valid, 0);

    // Back-to-back XOR stream, one per cycle.
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("b2b valid", out_valid, 1);
        chk("b2b result", result, xq.pop_front());
      end
      if (i < 8) begin
        xa = $urandom; xb = $urandom;
        in_valid = 1'b1; mode = 4'd4; op1 = xa; op2 = xb;
        xq.push_back(xa ^ xb);
        chk("b2b in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    for (int i = 0; i < 60; i++) run_op(4'($urandom_range(0, 15)), pick(), pick());

    // Reset during a multiply aborts it for good.
    @(negedge clk);
    in_valid = 1'b1; mode = 4'd11; op1 = 32'd7; op2 = 32'd6; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort no result", seen, 0);

    // MUL disabled build.
    @(negedge clk);
    in_valid2 = 1'b1; mode2 = 4'd11; op1_2 = 32'd7; op2_2 = 32'd6; out_ready2 = 1'b1;
    chk("nomul in_ready", in_ready2, 1);
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    @(negedge clk);
    chk("nomul out_valid", out_valid2, 1);
    chk("nomul result", result2, 0);
    chk("nomul err", err2, 1);
    chk("nomul zero", fz2, 1);
    chk("nomul neg/carry", {fn2, fc2}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
